// File: rtl/bpu_pkg.sv
// Shared encodings for the branch predict unit: branch/jump codes, next-PC
// source selects and 2-bit counter states.
package bpu_pkg;

   localparam logic [2:0] BR_NOB  = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BLT  = 3'b011;
   localparam logic [2:0] BR_BGE  = 3'b100;
   localparam logic [2:0] BR_BLTU = 3'b101;
   localparam logic [2:0] BR_BGEU = 3'b110;

   localparam logic [1:0] JMP_NOJ  = 2'b00;
   localparam logic [1:0] JMP_JAL  = 2'b01;
   localparam logic [1:0] JMP_JALR = 2'b10;

   localparam logic [1:0] PCSRC_SEQ     = 2'b00;
   localparam logic [1:0] PCSRC_TGT     = 2'b01;
   localparam logic [1:0] PCSRC_JALR    = 2'b10;
   localparam logic [1:0] PCSRC_RECOVER = 2'b11;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // Codes 001..110 are conditional branches; 000 and reserved 111 are not.
   function automatic logic is_cond_br(input logic [2:0] code);
      return (code >= BR_BEQ) && (code <= BR_BGEU);
   endfunction

endpackage

// File: rtl/bpu_bht.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters with one
// combinational read port and one saturating-update write port.
module bpu_bht
   import bpu_pkg::*;
#(
   parameter int unsigned IDX_BITS = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [1:0]          rd_cnt_c,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_taken
);

   localparam int unsigned DEPTH = 1 << IDX_BITS;

   logic [1:0] cnt_q [DEPTH];
   logic [1:0] cur_cnt;
   logic [1:0] nxt_cnt;

   // Read returns the pre-update value; no write bypass.
   assign rd_cnt_c = cnt_q[rd_idx];

   always_comb begin
      cur_cnt = cnt_q[wr_idx];
      nxt_cnt = cur_cnt;
      if (wr_taken && (cur_cnt != CNT_ST))
         nxt_cnt = cur_cnt + 2'd1;
      else if (!wr_taken && (cur_cnt != CNT_SNT))
         nxt_cnt = cur_cnt - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            cnt_q[IDX_BITS'(i)] <= CNT_WNT;
      end else if (wr_en) begin
         cnt_q[wr_idx] <= nxt_cnt;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, misprediction recovery and BHT training for EX.
// Optional perf counters are built when BPU_PERF_EN is defined.
module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned IDX_BITS = 6,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  pcF,
   output logic             predTakenF,
   input  logic [XLEN-1:0]  pcE,
   input  logic             validE,
   input  logic             stallE,
   input  logic [2:0]       branchE,
   input  logic [1:0]       jumpE,
   input  logic             zero,
   input  logic             neg,
   input  logic             ltu,
   input  logic             predTakenE,
   output logic [1:0]       PCSrcE,
   output logic             flushE,
   output logic [CNT_W-1:0] branchCnt,
   output logic [CNT_W-1:0] mispredCnt
);

   logic [IDX_BITS-1:0] idx_f;
   logic [IDX_BITS-1:0] idx_e;
   logic [1:0]          cnt_f;
   logic                cond_br;
   logic                taken_e;
   logic                mispred;
   logic                train;
   logic                unused_pc_bits;

   assign idx_f   = pcF[IDX_BITS+1:2];
   assign idx_e   = pcE[IDX_BITS+1:2];
   assign unused_pc_bits = ^{pcF[XLEN-1:IDX_BITS+2], pcF[1:0],
                             pcE[XLEN-1:IDX_BITS+2], pcE[1:0], cnt_f[0]};

   assign cond_br = validE && is_cond_br(branchE);
   assign mispred = cond_br && (taken_e ^ predTakenE);
   assign train   = cond_br && !stallE;

   always_comb begin
      taken_e = 1'b0;
      case (branchE)
         BR_BEQ:  taken_e = zero;
         BR_BNE:  taken_e = !zero;
         BR_BLT:  taken_e = neg;
         BR_BGE:  taken_e = !neg;
         BR_BLTU: taken_e = ltu;
         BR_BGEU: taken_e = !ltu;
         default: taken_e = 1'b0;
      endcase
   end

   // Next-PC select; a conditional branch overrides any jump code.
   always_comb begin
      PCSrcE = PCSRC_SEQ;
      flushE = 1'b0;
      if (cond_br) begin
         if (taken_e && !predTakenE) begin
            PCSrcE = PCSRC_TGT;
            flushE = 1'b1;
         end else if (!taken_e && predTakenE) begin
            PCSrcE = PCSRC_RECOVER;
            flushE = 1'b1;
         end
      end else if (validE && (branchE == BR_NOB)) begin
         if (jumpE == JMP_JAL) begin
            PCSrcE = PCSRC_TGT;
            flushE = 1'b1;
         end else if (jumpE == JMP_JALR) begin
            PCSrcE = PCSRC_JALR;
            flushE = 1'b1;
         end else if (jumpE == JMP_NOJ) begin
            PCSrcE = PCSRC_SEQ;
         end
      end
   end

   bpu_bht #(
      .IDX_BITS (IDX_BITS)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (idx_f),
      .rd_cnt_c (cnt_f),
      .wr_en    (train),
      .wr_idx   (idx_e),
      .wr_taken (taken_e)
   );

   assign predTakenF = cnt_f[1];

`ifdef BPU_PERF_EN
   logic [CNT_W-1:0] branch_q;
   logic [CNT_W-1:0] mispred_q;

   // Saturating perf counters, stepped once per branch as it leaves EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_q  <= '0;
         mispred_q <= '0;
      end else if (train) begin
         if (branch_q != '1)
            branch_q <= branch_q + CNT_W'(1);
         if (mispred && (mispred_q != '1))
            mispred_q <= mispred_q + CNT_W'(1);
      end
   end

   assign branchCnt  = branch_q;
   assign mispredCnt = mispred_q;
`else
   assign branchCnt  = '0;
   assign mispredCnt = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus
// randomized EX traffic checked against a behavioural table/counter model.
module tb_branch_predict_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned IDXB  = 6;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned DEPTH = 1 << IDXB;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [XLEN-1:0]  pcF, pcE;
   logic             predTakenF;
   logic             validE, stallE;
   logic [2:0]       branchE;
   logic [1:0]       jumpE;
   logic             zero, neg, ltu, predTakenE;
   logic [1:0]       PCSrcE;
   logic             flushE;
   logic [CNT_W-1:0] branchCnt, mispredCnt;

   int checks = 0;
   int errors = 0;

   int model_tbl [DEPTH];
   int model_br;
   int model_mis;

   branch_predict_unit #(.XLEN(XLEN), .IDX_BITS(IDXB), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .pcF(pcF), .predTakenF(predTakenF),
      .pcE(pcE), .validE(validE), .stallE(stallE), .branchE(branchE),
      .jumpE(jumpE), .zero(zero), .neg(neg), .ltu(ltu),
      .predTakenE(predTakenE), .PCSrcE(PCSrcE), .flushE(flushE),
      .branchCnt(branchCnt), .mispredCnt(mispredCnt)
   );

   always #5 clk = ~clk;

   function automatic int idx_of(input logic [XLEN-1:0] pc);
      return int'((pc >> 2) % DEPTH);
   endfunction

   function automatic bit is_cond(input logic v, input logic [2:0] br);
      return v && (br >= 3'd1) && (br <= 3'd6);
   endfunction

   function automatic bit cond_taken(input logic [2:0] br, input logic z, input logic n, input logic l);
      case (br)
         3'd1: return z;
         3'd2: return !z;
         3'd3: return n;
         3'd4: return !n;
         3'd5: return l;
         3'd6: return !l;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] exp_pcsrc();
      bit t;
      if (!validE) return 2'd0;
      if (is_cond(validE, branchE)) begin
         t = cond_taken(branchE, zero, neg, ltu);
         if (t && !predTakenE) return 2'd1;
         if (!t && predTakenE) return 2'd3;
         return 2'd0;
      end
      if (branchE == 3'd0) begin
         if (jumpE == 2'd1) return 2'd1;
         if (jumpE == 2'd2) return 2'd2;
      end
      return 2'd0;
   endfunction

   function automatic logic exp_predf();
      return model_tbl[idx_of(pcF)] >= 2;
   endfunction

   function automatic int exp_br_cnt();
`ifdef BPU_PERF_EN
      return model_br;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_mis_cnt();
`ifdef BPU_PERF_EN
      return model_mis;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) model_tbl[i] = 1;
      model_br  = 0;
      model_mis = 0;
   endtask

   // Apply the architectural effect of the current EX inputs at the next edge.
   task automatic tick();
      bit t;
      int k;
      if (is_cond(validE, branchE) && !stallE) begin
         t = cond_taken(branchE, zero, neg, ltu);
         k = idx_of(pcE);
         model_tbl[k] = t ? ((model_tbl[k] < 3) ? model_tbl[k] + 1 : 3)
                          : ((model_tbl[k] > 0) ? model_tbl[k] - 1 : 0);
         if (model_br < 65535) model_br++;
         if ((t != predTakenE) && (model_mis < 65535)) model_mis++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic st, input logic [2:0] br, input logic [1:0] jp,
                         input logic z, input logic n, input logic l, input logic p,
                         input logic [XLEN-1:0] pce);
      validE = v; stallE = st; branchE = br; jumpE = jp;
      zero = z; neg = n; ltu = l; predTakenE = p; pcE = pce;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         pcF = XLEN'(i * 36);
         #1;
         checks++;
         if (predTakenF !== 1'b0) begin
            errors++;
            $display("FAIL reset_predf pc=%h got %b want 0", pcF, predTakenF);
         end
      end
      checks++;
      if (PCSrcE !== 2'd0 || flushE !== 1'b0) begin
         errors++;
         $display("FAIL reset_pcsrc got %b/%b want 00/0", PCSrcE, flushE);
      end
      checks++;
      if (branchCnt !== '0 || mispredCnt !== '0) begin
         errors++;
         $display("FAIL reset_perf got %0d/%0d want 0/0", branchCnt, mispredCnt);
      end
   endtask

   task automatic test_train_basic();
      pcF = 32'h40;
      set_ex(1, 0, 3'd1, 2'd0, 1, 0, 0, 0, 32'h40);
      checks++;
      if (predTakenF !== 1'b0 || PCSrcE !== 2'd1 || flushE !== 1'b1) begin
         errors++;
         $display("FAIL beq_first got pf=%b src=%b fl=%b want 0/01/1", predTakenF, PCSrcE, flushE);
      end
      tick();
      checks++;
      if (predTakenF !== 1'b1 || model_tbl[16] != 2) begin
         errors++;
         $display("FAIL beq_trained got %b want 1 (model %0d)", predTakenF, model_tbl[16]);
      end
      for (int i = 0; i < 4; i++) begin
         set_ex(1, 0, 3'd1, 2'd0, 1, 0, 0, 1, 32'h40);
         checks++;
         if (PCSrcE !== 2'd0 || flushE !== 1'b0) begin
            errors++;
            $display("FAIL beq_correct[%0d] got %b/%b want 00/0", i, PCSrcE, flushE);
         end
         tick();
      end
      set_ex(1, 0, 3'd1, 2'd0, 0, 0, 0, 1, 32'h40);
      checks++;
      if (PCSrcE !== 2'd3 || flushE !== 1'b1) begin
         errors++;
         $display("FAIL beq_recover got %b/%b want 11/1", PCSrcE, flushE);
      end
      tick();
      checks++;
      if (predTakenF !== 1'b1 || model_tbl[16] != 2) begin
         errors++;
         $display("FAIL beq_after_nt got %b want 1 (model %0d)", predTakenF, model_tbl[16]);
      end
      set_ex(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic test_conditions();
      for (int p = 0; p < 2; p++) begin
         set_ex(1, 1, 3'd3, 2'd0, 0, 0, 0, 1'(p), 32'h80);
         checks++;
         if (PCSrcE !== ((p == 1) ? 2'd3 : 2'd0)) begin
            errors++;
            $display("FAIL blt_nt pred=%0d got %b want %b", p, PCSrcE, (p == 1) ? 2'd3 : 2'd0);
         end
         set_ex(1, 1, 3'd6, 2'd0, 0, 0, 0, 1'(p), 32'h80);
         checks++;
         if (PCSrcE !== ((p == 0) ? 2'd1 : 2'd0)) begin
            errors++;
            $display("FAIL bgeu_t pred=%0d got %b want %b", p, PCSrcE, (p == 0) ? 2'd1 : 2'd0);
         end
      end
      set_ex(1, 0, 3'd2, 2'd2, 1, 0, 0, 0, 32'h80);
      checks++;
      if (PCSrcE !== 2'd0 || flushE !== 1'b0) begin
         errors++;
         $display("FAIL branch_over_jump got %b/%b want 00/0", PCSrcE, flushE);
      end
      tick();
      set_ex(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic test_jumps();
      pcF = 32'h100;
      set_ex(1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 32'h100);
      checks++;
      if (PCSrcE !== 2'd2 || flushE !== 1'b1) begin
         errors++;
         $display("FAIL jalr got %b/%b want 10/1", PCSrcE, flushE);
      end
      tick();
      checks++;
      if (predTakenF !== 1'b0) begin
         errors++;
         $display("FAIL jalr_no_train got %b want 0", predTakenF);
      end
      set_ex(0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 32'h100);
      checks++;
      if (PCSrcE !== 2'd0 || flushE !== 1'b0) begin
         errors++;
         $display("FAIL jalr_invalid got %b/%b want 00/0", PCSrcE, flushE);
      end
      set_ex(1, 0, 3'd7, 2'd1, 1, 1, 1, 0, 32'h100);
      checks++;
      if (PCSrcE !== 2'd0 || flushE !== 1'b0) begin
         errors++;
         $display("FAIL reserved_br got %b/%b want 00/0", PCSrcE, flushE);
      end
      tick();
   endtask

   task automatic test_stall();
      int br0;
      br0 = exp_br_cnt();
      pcF = 32'hC0;
      for (int i = 0; i < 3; i++) begin
         set_ex(1, 1, 3'd1, 2'd0, 1, 0, 0, 0, 32'hC0);
         checks++;
         if (PCSrcE !== 2'd1 || predTakenF !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d] got src=%b pf=%b want 01/0", i, PCSrcE, predTakenF);
         end
         tick();
      end
      set_ex(1, 0, 3'd1, 2'd0, 1, 0, 0, 0, 32'hC0);
      tick();
      set_ex(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (predTakenF !== 1'b1 || model_tbl[48] != 2) begin
         errors++;
         $display("FAIL stall_one_step got %b want 1 (model %0d)", predTakenF, model_tbl[48]);
      end
      checks++;
      if (int'(branchCnt) != exp_br_cnt() || exp_br_cnt() - br0 != ((exp_br_cnt() == 0) ? 0 : 1)) begin
         errors++;
         $display("FAIL stall_count got %0d want %0d", branchCnt, exp_br_cnt());
      end
   endtask

   task automatic test_random();
      logic [XLEN-1:0] pc_pool [4];
      pc_pool[0] = 32'h14; pc_pool[1] = 32'h2C; pc_pool[2] = 32'h40; pc_pool[3] = 32'h1FC;
      for (int n = 0; n < 300; n++) begin
         pcF = pc_pool[$urandom_range(0, 3)];
         set_ex(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                pc_pool[$urandom_range(0, 3)]);
         checks++;
         if (PCSrcE !== exp_pcsrc() || flushE !== (exp_pcsrc() != 2'd0) || predTakenF !== exp_predf()) begin
            errors++;
            $display("FAIL rand[%0d] br=%0d jp=%0d v=%b got src=%b fl=%b pf=%b want %b/%b/%b",
                     n, branchE, jumpE, validE, PCSrcE, flushE, predTakenF,
                     exp_pcsrc(), exp_pcsrc() != 2'd0, exp_predf());
         end
         tick();
      end
      set_ex(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (int'(branchCnt) != exp_br_cnt() || int'(mispredCnt) != exp_mis_cnt()) begin
         errors++;
         $display("FAIL rand_perf got %0d/%0d want %0d/%0d", branchCnt, mispredCnt, exp_br_cnt(), exp_mis_cnt());
      end
   endtask

   task automatic test_midreset();
      set_ex(1, 0, 3'd1, 2'd0, 1, 0, 0, 0, 32'h14);
      tick();
      set_ex(1, 0, 3'd2, 2'd0, 0, 0, 0, 0, 32'h2C);
      tick();
      pcF = 32'h14;
      #1;
      checks++;
      if (predTakenF !== exp_predf()) begin
         errors++;
         $display("FAIL pre_reset_idx5 got %b want %b", predTakenF, exp_predf());
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (predTakenF !== 1'b0 || branchCnt !== '0 || mispredCnt !== '0) begin
         errors++;
         $display("FAIL midreset got pf=%b cnt=%0d/%0d want 0/0/0", predTakenF, branchCnt, mispredCnt);
      end
      pcF = 32'h2C;
      #1;
      checks++;
      if (predTakenF !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idx11 got %b want 0", predTakenF);
      end
      set_ex(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
`ifdef BPU_PERF_EN
      force dut.mispred_q = 16'hFFFF;
      #1;
      release dut.mispred_q;
      model_mis = 65535;
      set_ex(1, 0, 3'd1, 2'd0, 1, 0, 0, 0, 32'h14);
      tick();
      set_ex(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (mispredCnt !== 16'hFFFF || int'(branchCnt) != model_br) begin
         errors++;
         $display("FAIL mispred_sat got %h/%0d want ffff/%0d", mispredCnt, branchCnt, model_br);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      pcF = '0;
      set_ex(0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 32'h0);
      model_reset();
      #8;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_train_basic();
      test_conditions();
      test_jumps();
      test_stall();
      test_random();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
